// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative, write-through CPU cache with LRU replacement.
// A miss fills the whole block one word at a time from a fixed-latency memory.
module cache_ctrl_2way #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int SETS        = 64,
  parameter int WORDS       = 8,
  parameter int WRITE_ALLOC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              dbg_state_o
);

  // Handshake: the CPU holds req/we/addr/wdata stable while stall=1; an access
  // completes in the first cycle it sees stall=0. Each mem_rd is one word and
  // mem_valid returns the words in issue order.

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
  localparam int BLK_W = TAG_W + IDX_W;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_lsb;

  assign off             = addr[OFF_W:1];
  assign idx             = addr[OFF_W+IDX_W:OFF_W+1];
  assign tag             = addr[ADDR_W-1:OFF_W+IDX_W+1];
  assign unused_addr_lsb = addr[0];

  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [DATA_W-1:0] data_q  [2][SETS*WORDS];

  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
  logic             victim_q, victim_d;
  logic [BLK_W-1:0] fill_blk_q, fill_blk_d;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign fill_idx = fill_blk_q[IDX_W-1:0];
  assign fill_tag = fill_blk_q[BLK_W-1:IDX_W];

  logic hit0, hit1, hit, hit_way;
  assign hit0    = req & valid_q[0][idx] & (tag_q[0][idx] == tag);
  assign hit1    = req & valid_q[1][idx] & (tag_q[1][idx] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  logic hit_upd, wr_hit, fill_start, fill_wr, fill_done;

  assign mem_wdata   = wdata;
  assign dbg_state_o = (state_q == S_FILL);

  always_comb begin
    state_d     = state_q;
    rdata       = '0;
    stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = addr;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    victim_d    = victim_q;
    fill_blk_d  = fill_blk_q;
    hit_upd     = 1'b0;
    wr_hit      = 1'b0;
    fill_start  = 1'b0;
    fill_wr     = 1'b0;
    fill_done   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req && hit) begin
            hit_upd = 1'b1;
            if (we) begin
              mem_wr = 1'b1;
              wr_hit = 1'b1;
            end else begin
              rdata = data_q[hit_way][{idx, off}];
            end
          end else if (req && we && (WRITE_ALLOC == 0)) begin
            mem_wr = 1'b1;
          end else if (req) begin
            // Victim priority: invalid way 0, then invalid way 1, then LRU way.
            stall       = 1'b1;
            state_d     = S_FILL;
            fill_start  = 1'b1;
            fill_blk_d  = addr[ADDR_W-1:OFF_W+1];
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            if (!valid_q[0][idx])      victim_d = 1'b0;
            else if (!valid_q[1][idx]) victim_d = 1'b1;
            else                       victim_d = lru_q[idx];
          end
        end
        S_FILL: begin
          stall = 1'b1;
          if (issue_cnt_q != WORDS_C) begin
            mem_rd      = 1'b1;
            mem_addr    = {fill_blk_q, issue_cnt_q[OFF_W-1:0], 1'b0};
            issue_cnt_d = issue_cnt_q + 1'b1;
          end
          if (mem_valid) begin
            fill_wr    = 1'b1;
            recv_cnt_d = recv_cnt_q + 1'b1;
            if (recv_cnt_q == LAST_C) begin
              fill_done   = 1'b1;
              state_d     = S_IDLE;
              issue_cnt_d = '0;
              recv_cnt_d  = '0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      victim_q    <= 1'b0;
      fill_blk_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      victim_q    <= victim_d;
      fill_blk_q  <= fill_blk_d;
    end
  end

  // The victim is invalidated on entry so an interrupted fill never reads as a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      if (hit_upd)    lru_q[idx] <= ~hit_way;
      if (fill_start) valid_q[victim_d][idx] <= 1'b0;
      if (fill_done) begin
        valid_q[victim_q][fill_idx] <= 1'b1;
        lru_q[fill_idx]             <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit)    data_q[hit_way][{idx, off}] <= wdata;
    if (fill_wr)   data_q[victim_q][{fill_idx, recv_cnt_q[OFF_W-1:0]}] <= mem_rdata;
    if (fill_done) tag_q[victim_q][fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way: three parameterisations share one CPU
// driver, a fixed-latency memory, and a set/way/LRU reference model.
module tb_cache_ctrl_2way;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [15:0] addr, wdata;
  logic [1:0]  sel;
  logic        mem_valid;
  logic [15:0] mem_rdata;

  logic [15:0] rdata_w [3];
  logic [15:0] mem_addr_w [3];
  logic [15:0] mem_wdata_w [3];
  logic        stall_w [3];
  logic        mem_rd_w [3];
  logic        mem_wr_w [3];
  logic        dbg_w [3];

  logic [15:0] s_rdata, s_mem_addr, s_mem_wdata;
  logic        s_stall, s_mem_rd, s_mem_wr, s_dbg;

  cache_ctrl_2way u_dut0 (
    .clk(clk), .rst(rst), .req(req && sel == 2'd0), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[0]), .stall(stall_w[0]), .mem_addr(mem_addr_w[0]), .mem_rd(mem_rd_w[0]),
    .mem_wr(mem_wr_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid && sel == 2'd0), .dbg_state_o(dbg_w[0])
  );

  cache_ctrl_2way #(.WRITE_ALLOC(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req && sel == 2'd1), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[1]), .stall(stall_w[1]), .mem_addr(mem_addr_w[1]), .mem_rd(mem_rd_w[1]),
    .mem_wr(mem_wr_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid && sel == 2'd1), .dbg_state_o(dbg_w[1])
  );

  cache_ctrl_2way #(.SETS(4), .WORDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req && sel == 2'd2), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[2]), .stall(stall_w[2]), .mem_addr(mem_addr_w[2]), .mem_rd(mem_rd_w[2]),
    .mem_wr(mem_wr_w[2]), .mem_wdata(mem_wdata_w[2]), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid && sel == 2'd2), .dbg_state_o(dbg_w[2])
  );

  always_comb begin
    s_rdata     = rdata_w[sel];
    s_mem_addr  = mem_addr_w[sel];
    s_mem_wdata = mem_wdata_w[sel];
    s_stall     = stall_w[sel];
    s_mem_rd    = mem_rd_w[sel];
    s_mem_wr    = mem_wr_w[sel];
    s_dbg       = dbg_w[sel];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory seen by the DUT (written by DUT mem_wr) and golden memory (written by stimulus).
  logic [15:0] mem [32768];
  logic [15:0] ref_mem [32768];

  logic [15:0] exp_rd_q [$];
  logic [15:0] exp_wr_q [$];
  int          rd_cnt;
  logic [15:0] rd_first, rd_last, wr_seen;
  int          vcount = 0;

  // Reference model: per DUT, per way, per set valid/tag, plus per-set LRU way.
  bit m_valid [3][2][64];
  int m_tag   [3][2][64];
  bit m_lru   [3][64];

  function automatic int words_of(input logic [1:0] d);
    return (d == 2'd2) ? 2 : 8;
  endfunction

  function automatic int sets_of(input logic [1:0] d);
    return (d == 2'd2) ? 4 : 64;
  endfunction

  function automatic bit alloc_of(input logic [1:0] d);
    return (d == 2'd1);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 64; s++) begin
        m_valid[d][0][s] = 1'b0;
        m_valid[d][1][s] = 1'b0;
        m_tag[d][0][s]   = 0;
        m_tag[d][1][s]   = 0;
        m_lru[d][s]      = 1'b0;
      end
  endtask

  // Fixed-latency memory: a read seen in cycle k returns its word in cycle k+LAT.
  logic [16:0] pipe [LAT];
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        mem_valid = 1'b0;
      end else begin
        mem_valid = pipe[LAT-1][16];
        mem_rdata = mem[pipe[LAT-1][15:1]];
        if (mem_valid) vcount++;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = {s_mem_rd, s_mem_addr};
      end
    end
  end

  // Per-cycle compare against the expected memory traffic and output rules.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("rst_stall", s_stall, 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_mem_rd", s_mem_rd, 0);
        check("rst_mem_wr", s_mem_wr, 0);
        check("rst_state", s_dbg, 0);
      end else begin
        check("rd_wr_exclusive", s_mem_rd & s_mem_wr, 0);
        if (!(req && !we && !s_stall)) check("rdata_zero", s_rdata, 0);
        if (s_mem_rd) begin
          if (exp_rd_q.size() == 0) check("mem_rd_unexpected", s_mem_addr, 16'hFFFF);
          else check("mem_rd_addr", s_mem_addr, exp_rd_q.pop_front());
          if (rd_cnt == 0) rd_first = s_mem_addr;
          rd_last = s_mem_addr;
          rd_cnt++;
        end
        if (s_mem_wr) begin
          if (exp_wr_q.size() == 0) check("mem_wr_unexpected", s_mem_addr, 16'hFFFF);
          else check("mem_wr_addr", s_mem_addr, exp_wr_q.pop_front());
          check("mem_wdata", s_mem_wdata, wdata);
          mem[s_mem_addr[15:1]] = s_mem_wdata;
          wr_seen = s_mem_addr;
        end
      end
    end
  end

  logic [15:0] last_rdata;
  int          last_cyc;
  bit          last_hit;

  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d);
    int nw, ns, blk, idx, tg, way, victim;
    bit fill;
    nw  = words_of(sel);
    ns  = sets_of(sel);
    blk = int'(a) / (2 * nw);
    idx = blk % ns;
    tg  = blk / ns;
    way = -1;
    for (int k = 0; k < 2; k++)
      if (m_valid[sel][k][idx] && m_tag[sel][k][idx] == tg) way = k;
    fill     = (way < 0) && (!w || alloc_of(sel));
    last_hit = (way >= 0);
    rd_cnt   = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    if (w && !fill) exp_wr_q.push_back(a);
    @(negedge clk);
    check("stall_first", s_stall, fill);
    last_cyc = 1;
    if (fill) begin
      if (!m_valid[sel][0][idx])      victim = 0;
      else if (!m_valid[sel][1][idx]) victim = 1;
      else                            victim = int'(m_lru[sel][idx]);
      m_valid[sel][victim][idx] = 1'b0;
      for (int i = 0; i < nw; i++) exp_rd_q.push_back(16'(blk * 2 * nw + 2 * i));
      while (s_stall && last_cyc < 300) begin
        @(negedge clk);
        last_cyc++;
      end
      check("fill_cycles", last_cyc, 2 + nw + LAT);
      check("fill_rd_left", exp_rd_q.size(), 0);
      m_valid[sel][victim][idx] = 1'b1;
      m_tag[sel][victim][idx]   = tg;
      way = victim;
      if (w) exp_wr_q.push_back(a);
    end
    last_rdata = s_rdata;
    if (!w) check("rdata", s_rdata, ref_mem[a[15:1]]);
    else ref_mem[a[15:1]] = d;
    if (way >= 0) m_lru[sel][idx] = (way == 0);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    check("wr_pending", exp_wr_q.size(), 0);
  endtask

  initial begin
    int v0, t;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 2'd0;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'(i * 2) ^ 16'hC3C3;
      ref_mem[i] = 16'(i * 2) ^ 16'hC3C3;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold read miss, then a hit in the same block.
    do_access(1'b0, 16'h1234, 16'h0);
    check("cold_rdata_lit", last_rdata, 16'hD1F7);
    check("cold_cycles_lit", last_cyc, 14);
    check("cold_rd_cnt", rd_cnt, 8);
    check("cold_rd_first", rd_first, 16'h1230);
    check("cold_rd_last", rd_last, 16'h123E);
    do_access(1'b0, 16'h123E, 16'h0);
    check("hit_lit", last_hit, 1);
    check("hit_rdata_lit", last_rdata, 16'hD1FD);
    check("hit_cycles_lit", last_cyc, 1);

    // Write hit, then read back.
    do_access(1'b1, 16'h1236, 16'hBEEF);
    check("wr_hit_addr_lit", wr_seen, 16'h1236);
    do_access(1'b0, 16'h1236, 16'h0);
    check("wr_hit_read_lit", last_rdata, 16'hBEEF);
    check("wr_hit_read_cyc", last_cyc, 1);

    // Same index, tags A/B/C: C evicts A, B survives, A misses.
    do_access(1'b0, 16'h1634, 16'h0);
    check("evict_b_miss", last_hit, 0);
    do_access(1'b0, 16'h1A34, 16'h0);
    check("evict_c_miss", last_hit, 0);
    do_access(1'b0, 16'h1634, 16'h0);
    check("evict_b_hit", last_hit, 1);
    do_access(1'b0, 16'h1234, 16'h0);
    check("evict_a_miss", last_hit, 0);
    check("evict_a_rdata", last_rdata, 16'hD1F7);

    // Write miss without allocation.
    do_access(1'b1, 16'h2000, 16'h1111);
    check("wmiss_cyc", last_cyc, 1);
    check("wmiss_addr", wr_seen, 16'h2000);
    do_access(1'b0, 16'h2000, 16'h0);
    check("wmiss_read_miss", last_hit, 0);
    check("wmiss_read_lit", last_rdata, 16'h1111);

    // Reset after the third returned word of a fill.
    v0 = vcount;
    req = 1'b1; we = 1'b0; addr = 16'h3000;
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(16'(16'h3000 + 2 * i));
    t = 0;
    while (vcount < v0 + 3 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("rst_fill_wait", t < 100, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_now_stall", s_stall, 0);
    check("rst_now_state", s_dbg, 0);
    check("rst_now_rd", s_mem_rd, 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 req = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
    do_access(1'b0, 16'h3000, 16'h0);
    check("rst_refill_miss", last_hit, 0);
    check("rst_refill_cnt", rd_cnt, 8);
    check("rst_refill_lit", last_rdata, 16'hF3C3);

    // Write-allocate instance: fill, then the write completes as a hit.
    sel = 2'd1;
    do_access(1'b1, 16'h4000, 16'h2222);
    check("walloc_cycles", last_cyc, 14);
    check("walloc_rd_cnt", rd_cnt, 8);
    check("walloc_wr_addr", wr_seen, 16'h4000);
    do_access(1'b0, 16'h4000, 16'h0);
    check("walloc_hit", last_hit, 1);
    check("walloc_rdata", last_rdata, 16'h2222);

    // Small instance: SETS=4, WORDS=2.
    sel = 2'd2;
    do_access(1'b0, 16'h0104, 16'h0);
    check("small_rd_cnt", rd_cnt, 2);
    check("small_cycles", last_cyc, 8);
    check("small_rd_first", rd_first, 16'h0104);
    check("small_rd_last", rd_last, 16'h0106);
    do_access(1'b0, 16'h0106, 16'h0);
    check("small_hit", last_hit, 1);
    do_access(1'b0, 16'h0114, 16'h0);
    check("small_rd_cnt2", rd_cnt, 2);
    do_access(1'b0, 16'h0124, 16'h0);
    do_access(1'b0, 16'h0114, 16'h0);
    check("small_keep_hit", last_hit, 1);
    do_access(1'b0, 16'h0104, 16'h0);
    check("small_evicted", last_hit, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_2way.md
CACHE_CTRL_2WAY -- requirements
Module: cache_ctrl_2way

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 16: word width, 2 bytes per word; addr[0] is ignored.
REQ-003 The block SHALL have parameter SETS, default 64: sets per way; must be a power of 2 and at least 2.
REQ-004 The block SHALL have parameter WORDS, default 8: words per block; must be a power of 2 and at least 2.
REQ-005 The block SHALL have parameter WRITE_ALLOC, default 0: 1 = write-allocate, 0 = write-no-allocate.
REQ-006 The block SHALL have the following ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  CPU access request; held stable by the CPU while stall=1.
- we  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; combinational.
- stall  out  1  CPU must hold its request; combinational.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  one-word memory read request.
- mem_wr  out  1  one-word memory write.
- mem_wdata  out  DATA_W  equals wdata.
- mem_rdata  in  DATA_W  returned memory read data.
- mem_valid  in  1  mem_rdata is valid; responses return in issue order with fixed latency of at least 1 cycle.

Function
REQ-007 Address split SHALL be offset = addr[log2(WORDS):1], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-008 Each set SHALL hold two ways, each with a valid bit, tag and WORDS data words, plus one LRU bit naming the way to evict next.
REQ-009 Hit SHALL be defined as req & valid & tag match in either way; at most one way may match.
REQ-010 FSM states SHALL be IDLE and FILL only.
REQ-011 In IDLE, a read hit SHALL drive rdata with the hit word and stall=0 in the same cycle, and set the set's LRU bit to the other way.
REQ-012 rdata SHALL be 0 whenever there is no read hit in IDLE.
REQ-013 In IDLE, a write hit SHALL write wdata into the hit word at the clock edge, pulse mem_wr=1 for one cycle with mem_addr=addr, hold stall=0, and update LRU.
REQ-014 A write miss with WRITE_ALLOC=0 SHALL pulse mem_wr for one cycle, hold stall=0, and leave tags, data and LRU unchanged.
REQ-015 A read miss, or a write miss with WRITE_ALLOC=1, SHALL assert stall in the same cycle and move to FILL on the next edge.
REQ-016 Victim selection SHALL be latched on FILL entry in this priority order: invalid way 0, else invalid way 1, else the LRU way.
REQ-017 On FILL entry the victim's valid bit SHALL be cleared.
REQ-018 In FILL the block SHALL issue mem_rd on WORDS consecutive cycles with mem_addr = block base + 2*i, i = 0..WORDS-1 (issue counter).
REQ-019 In FILL, each mem_valid SHALL write mem_rdata into the victim word indexed by a receive counter, then increment that counter.
REQ-020 On the WORDS-th mem_valid the block SHALL write the tag, set valid, set LRU to the non-victim way, clear both counters and return to IDLE.
REQ-021 stall SHALL be 1 throughout FILL.
REQ-022 After FILL completes, the held request re-evaluates as a hit in IDLE; a write therefore completes per REQ-013.
REQ-023 mem_valid in IDLE SHALL be ignored.
REQ-024 Deassertion of req during FILL SHALL NOT abort the fill.
REQ-025 mem_rd and mem_wr SHALL never be asserted in the same cycle.
REQ-026 Counter widths SHALL be log2(WORDS)+1 bits so that a count of WORDS is representable with no wrap.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE, clear all valid and LRU bits to 0, clear both counters, and clear the latched victim.
REQ-028 During reset, outputs SHALL be mem_rd=0, mem_wr=0, stall=0, rdata=0; data arrays need not be cleared.
REQ-029 Reset mid-FILL SHALL discard the partial fill; the set reads as a miss afterwards.

Verification
REQ-030 Default parameters, cold read of 0x1234 with memory latency 4 -> stall=1; 8 mem_rd at 0x1230..0x123E; stall falls after the 8th mem_valid; rdata = mem[0x1234]; the next read to 0x123E hits with stall=0.
REQ-031 Three fills to the same index with different tags A, B, C, then a read of A -> C evicts A (the LRU way), B survives, and the read of A misses.
REQ-032 Write hit to 0x1236 with 0xBEEF -> mem_wr pulses once with mem_addr=0x1236; a subsequent read returns 0xBEEF with stall=0.
REQ-033 Write miss -> with WRITE_ALLOC=0, single mem_wr, stall=0, and a later read misses; with WRITE_ALLOC=1, a fill occurs, then mem_wr and a hit.
REQ-034 rst asserted after the 3rd mem_valid of a fill -> immediate IDLE, stall=0, and a re-read misses and refills all 8 words.
REQ-035 SETS=4, WORDS=2 -> fill issues exactly 2 mem_rd, and the counters do not wrap.
